// File: rtl/mem_io_responder_if.sv
// Controller/UART-facing signal bundle of the RAM/IO responder.
// master is the environment side (controller + UART); slave is the responder.
interface mem_io_responder_if;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        halt;
    logic        tx_overflow;

    modport master (
        output mem_addr, mem_wr, mem_din, tx_ready, rx_data, rx_valid,
        input  mem_dout, io_buffer_full, tx_data, tx_valid, rx_pop, halt, tx_overflow
    );

    modport slave (
        input  mem_addr, mem_wr, mem_din, tx_ready, rx_data, rx_valid,
        output mem_dout, io_buffer_full, tx_data, tx_valid, rx_pop, halt, tx_overflow
    );
endinterface

// File: rtl/mem_io_responder.sv
// Byte-wide memory-side responder: block RAM plus an IO window at addr[17:16]==2'b11
// holding the UART TX FIFO, the RX byte port and the simulation halt register.
module mem_io_responder #(
    parameter int    ADDR_WIDTH = 17,
    parameter int    TX_DEPTH   = 8,
    parameter string INIT_FILE  = "test.data"
) (
    input  logic                clk,
    input  logic                rst,
    mem_io_responder_if.slave   bus
);
    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0] OFF_TX   = 16'h0000;
    localparam logic [15:0] OFF_HALT = 16'h0004;

    // The RAM image named by INIT_FILE is attached by the memory-init step of the build flow.
    logic [7:0] ram [2**ADDR_WIDTH];
    logic [7:0] fifo [TX_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, next_count;

    logic                  is_io;
    logic [15:0]           io_off;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  ram_we;
    logic                  push_req, push_ok, pop, fifo_full;
    logic                  halt_we;
    logic                  unused_addr_hi;

    assign is_io          = (bus.mem_addr[17:16] == 2'b11);
    assign io_off         = bus.mem_addr[15:0];
    assign ram_idx        = bus.mem_addr[ADDR_WIDTH-1:0];
    assign unused_addr_hi = ^bus.mem_addr[31:18];

    assign ram_we    = bus.mem_wr && !is_io;
    assign push_req  = bus.mem_wr && is_io && (io_off == OFF_TX);
    assign halt_we   = bus.mem_wr && is_io && (io_off == OFF_HALT);
    assign fifo_full = (count == CNT_W'(TX_DEPTH));
    assign pop       = bus.tx_valid && bus.tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = push_req && (!fifo_full || pop);

    assign next_count   = count + CNT_W'(push_ok) - CNT_W'(pop);
    assign bus.tx_valid = (count != '0);
    assign bus.tx_data  = fifo[rd_ptr];

    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram[ram_idx] <= bus.mem_din;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            fifo[wr_ptr] <= bus.mem_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_dout <= '0;
            bus.rx_pop   <= 1'b0;
        end else begin
            bus.rx_pop <= 1'b0;
            if (!bus.mem_wr) begin
                if (!is_io) begin
                    bus.mem_dout <= ram[ram_idx];
                end else if (io_off == OFF_TX) begin
                    bus.mem_dout <= bus.rx_valid ? bus.rx_data : 8'h00;
                    bus.rx_pop   <= bus.rx_valid;
                end else if (io_off == OFF_HALT) begin
                    bus.mem_dout <= {7'b0, bus.tx_valid};
                end else begin
                    bus.mem_dout <= 8'h00;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            bus.io_buffer_full <= 1'b0;
            bus.tx_overflow    <= 1'b0;
            bus.halt           <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= next_count;
            // Two-slot margin covers the controller's decision-to-write pipeline.
            bus.io_buffer_full <= (next_count >= CNT_W'(TX_DEPTH - 2));
            if (push_req && !push_ok) begin
                bus.tx_overflow <= 1'b1;
            end
            if (halt_we) begin
                bus.halt <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a queue/array reference model checked every cycle,
// plus literal expectations for the main scenarios.
module tb_mem_io_responder;
    localparam int TX_DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mem_io_responder_if bus();

    mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(TX_DEPTH), .INIT_FILE("test.data")) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [7:0] mram [int];
    logic [7:0] q [$];
    logic [7:0] m_dout   = 8'h00;
    logic       m_known  = 1'b1;
    logic       m_rx_pop = 1'b0;
    logic       m_full   = 1'b0;
    logic       m_halt   = 1'b0;
    logic       m_ovf    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge rst) begin
        q.delete();
        m_dout   = 8'h00;
        m_known  = 1'b1;
        m_rx_pop = 1'b0;
        m_full   = 1'b0;
        m_halt   = 1'b0;
        m_ovf    = 1'b0;
    end

    always @(posedge clk) begin
        logic        io;
        logic [15:0] off;
        int          idx;
        logic        was_valid;
        if (!rst) begin
            io        = (bus.mem_addr[17:16] == 2'b11);
            off       = bus.mem_addr[15:0];
            idx       = int'(bus.mem_addr[16:0]);
            was_valid = (q.size() != 0);
            m_rx_pop  = 1'b0;
            if (!bus.mem_wr) begin
                m_known = 1'b1;
                if (!io) begin
                    if (mram.exists(idx)) m_dout = mram[idx];
                    else m_known = 1'b0;
                end else if (off == 16'h0000) begin
                    m_dout   = bus.rx_valid ? bus.rx_data : 8'h00;
                    m_rx_pop = bus.rx_valid;
                end else if (off == 16'h0004) begin
                    m_dout = {7'b0, was_valid};
                end else begin
                    m_dout = 8'h00;
                end
            end
            if (was_valid && bus.tx_ready) void'(q.pop_front());
            if (bus.mem_wr && io && off == 16'h0000) begin
                if (q.size() < TX_DEPTH) q.push_back(bus.mem_din);
                else m_ovf = 1'b1;
            end
            if (bus.mem_wr && io && off == 16'h0004) m_halt = 1'b1;
            if (bus.mem_wr && !io) mram[idx] = bus.mem_din;
            m_full = (q.size() >= TX_DEPTH - 2);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_known) check("model_dout", {24'h0, bus.mem_dout}, {24'h0, m_dout});
            check("model_rx_pop", {31'h0, bus.rx_pop}, {31'h0, m_rx_pop});
            check("model_full", {31'h0, bus.io_buffer_full}, {31'h0, m_full});
            check("model_tx_valid", {31'h0, bus.tx_valid}, {31'h0, q.size() != 0});
            if (q.size() != 0) check("model_tx_data", {24'h0, bus.tx_data}, {24'h0, q[0]});
            check("model_halt", {31'h0, bus.halt}, {31'h0, m_halt});
            check("model_ovf", {31'h0, bus.tx_overflow}, {31'h0, m_ovf});
        end
    end

    task automatic cyc(input logic [31:0] a, input logic w, input logic [7:0] d);
        bus.mem_addr = a;
        bus.mem_wr   = w;
        bus.mem_din  = d;
        @(negedge clk);
        bus.mem_addr = 32'h0;
        bus.mem_wr   = 1'b0;
        bus.mem_din  = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"},  {24'h0, bus.mem_dout}, 32'h0);
        check({tag, "_txv"},   {31'h0, bus.tx_valid}, 32'h0);
        check({tag, "_full"},  {31'h0, bus.io_buffer_full}, 32'h0);
        check({tag, "_halt"},  {31'h0, bus.halt}, 32'h0);
        check({tag, "_ovf"},   {31'h0, bus.tx_overflow}, 32'h0);
        check({tag, "_rxpop"}, {31'h0, bus.rx_pop}, 32'h0);
    endtask

    initial begin
        logic [7:0] exp_seq [4];
        logic [7:0] drain2 [8];
        bus.mem_addr = 32'h0;
        bus.mem_wr   = 1'b0;
        bus.mem_din  = 8'h00;
        bus.tx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        exp_seq = '{8'hAB, 8'hCD, 8'hEF, 8'h12};
        dut.ram[0] = 8'h00;  mram[0] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            dut.ram[16 + i] = exp_seq[i];
            mram[16 + i]    = exp_seq[i];
        end

        #1;
        check_all_zero("reset");
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // RAM read latency and back-to-back streaming
        cyc(32'h10, 1'b0, 8'h00);
        check("rd_0x10", {24'h0, bus.mem_dout}, 32'hAB);
        for (int i = 0; i < 4; i++) begin
            cyc(32'h10 + i, 1'b0, 8'h00);
            check("stream", {24'h0, bus.mem_dout}, {24'h0, exp_seq[i]});
        end

        // write holds dout, then read-back and aliasing
        cyc(32'h200, 1'b1, 8'h5A);
        check("wr_hold_dout", {24'h0, bus.mem_dout}, 32'h12);
        cyc(32'h200, 1'b0, 8'h00);
        check("rd_0x200", {24'h0, bus.mem_dout}, 32'h5A);
        cyc(32'h20200, 1'b0, 8'h00);
        check("alias_0x20200", {24'h0, bus.mem_dout}, 32'h5A);

        // fill the TX FIFO with the UART stalled
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(32'h30000, 1'b1, 8'h41 + 8'(i));
            check("fill_full_flag", {31'h0, bus.io_buffer_full}, {31'h0, i >= 5});
        end
        check("ovf_before", {31'h0, bus.tx_overflow}, 32'h0);
        cyc(32'h30000, 1'b1, 8'h50);
        check("ovf_after", {31'h0, bus.tx_overflow}, 32'h1);
        cyc(32'h30004, 1'b0, 8'h00);
        check("status_rd", {24'h0, bus.mem_dout}, 32'h1);
        cyc(32'h30008, 1'b1, 8'hFF);
        check("other_wr_no_halt", {31'h0, bus.halt}, 32'h0);
        cyc(32'h30008, 1'b0, 8'h00);
        check("other_rd", {24'h0, bus.mem_dout}, 32'h0);

        // drain in order
        bus.tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("drain1", {24'h0, bus.tx_data}, {24'h0, 8'h41 + 8'(k)});
            cyc(32'h0, 1'b0, 8'h00);
        end
        check("drain1_empty", {31'h0, bus.tx_valid}, 32'h0);
        cyc(32'h30004, 1'b0, 8'h00);
        check("status_empty", {24'h0, bus.mem_dout}, 32'h0);

        // full FIFO with a simultaneous pop and push
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) cyc(32'h30000, 1'b1, 8'h61 + 8'(i));
        bus.tx_ready = 1'b1;
        cyc(32'h30000, 1'b1, 8'h49);
        check("simul_full", {31'h0, bus.io_buffer_full}, 32'h1);
        drain2 = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h49};
        for (int k = 0; k < 8; k++) begin
            check("drain2", {24'h0, bus.tx_data}, {24'h0, drain2[k]});
            check("drain2_valid", {31'h0, bus.tx_valid}, 32'h1);
            cyc(32'h0, 1'b0, 8'h00);
        end
        check("drain2_empty", {31'h0, bus.tx_valid}, 32'h0);
        bus.tx_ready = 1'b0;

        // RX byte port
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h33;
        cyc(32'h30000, 1'b0, 8'h00);
        check("rx_data", {24'h0, bus.mem_dout}, 32'h33);
        check("rx_pop", {31'h0, bus.rx_pop}, 32'h1);
        cyc(32'h10, 1'b0, 8'h00);
        check("rx_pop_single", {31'h0, bus.rx_pop}, 32'h0);
        bus.rx_valid = 1'b0;
        cyc(32'h30000, 1'b0, 8'h00);
        check("rx_empty_data", {24'h0, bus.mem_dout}, 32'h0);
        check("rx_empty_pop", {31'h0, bus.rx_pop}, 32'h0);

        // halt, then asynchronous reset mid-stream
        cyc(32'h30004, 1'b1, 8'h00);
        check("halt_set", {31'h0, bus.halt}, 32'h1);
        cyc(32'h30000, 1'b1, 8'h77);
        cyc(32'h30000, 1'b1, 8'h78);
        cyc(32'h10, 1'b0, 8'h00);
        check("pre_rst_dout", {24'h0, bus.mem_dout}, 32'hAB);
        bus.mem_addr = 32'h300;
        bus.mem_wr   = 1'b1;
        bus.mem_din  = 8'h99;
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        bus.mem_addr = 32'h0;
        bus.mem_wr   = 1'b0;
        bus.mem_din  = 8'h00;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        cyc(32'h10, 1'b0, 8'h00);
        check("ram_kept_0x10", {24'h0, bus.mem_dout}, 32'hAB);
        cyc(32'h200, 1'b0, 8'h00);
        check("ram_kept_0x200", {24'h0, bus.mem_dout}, 32'h5A);
        check("halt_cleared", {31'h0, bus.halt}, 32'h0);
        cyc(32'h0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
